// File: rtl/nonzero_match_picker.sv
// rtl/nonzero_match_picker.sv - emits surviving AND-mask positions with IFM/filter compressed offsets
//
// Takes one chunk of the IFM & filter match mask together with both original
// sparsity bitmaps, then walks the match mask lowest bit first, producing one
// descriptor per cycle: bit position plus the prefix popcounts of each bitmap
// strictly below that position (the offsets into the compressed data arrays).
//
// Optional feature macro: MATCH_PICKER_CNT_EN (adds match_cnt_o).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o chunk handshake
//   and_mask_i            IFM & filter match mask for the chunk
//   IFM_mask_i            IFM sparsity bitmap for the chunk
//   filter_mask_i         filter sparsity bitmap for the chunk
//   out_valid_o/out_ready_i descriptor handshake
//   pos_o                 bit position of the current match
//   ifm_idx_o             IFM bits set strictly below pos_o
//   filt_idx_o            filter bits set strictly below pos_o
//   last_o                final match of the chunk
//   empty_o               one-cycle pulse after accepting a chunk with no matches
//   match_cnt_o           saturating count of completed output handshakes

`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif

module nonzero_match_picker #(
    parameter int SIZE  = `PREFIX_SUM_SIZE,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SIZE-1:0]  and_mask_i,
    input  logic [SIZE-1:0]  IFM_mask_i,
    input  logic [SIZE-1:0]  filter_mask_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] pos_o,
    output logic [IDX_W-1:0] ifm_idx_o,
    output logic [IDX_W-1:0] filt_idx_o,
    output logic             last_o,
    output logic             empty_o
`ifdef MATCH_PICKER_CNT_EN
    ,
    output logic [15:0]      match_cnt_o
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] rem_q, ifm_q, filt_q;
    logic            empty_q;

    logic [SIZE-1:0] low_bit;
    logic [SIZE-1:0] below_mask;
    logic [SIZE-1:0] rem_next;
    logic [IDX_W-1:0] low_pos;
    logic            one_left;
    logic            accept;
    logic            handshake;

    function automatic logic [IDX_W-1:0] popcount(input logic [SIZE-1:0] v);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int i = 0; i < SIZE; i++) begin
            c = c + IDX_W'(v[i]);
        end
        return c;
    endfunction

    // Two's-complement trick isolates the lowest set bit; subtracting one from
    // it yields the mask of all positions strictly below the current match.
    assign low_bit    = rem_q & (~rem_q + SIZE'(1));
    assign below_mask = low_bit - SIZE'(1);
    assign rem_next   = rem_q & (rem_q - SIZE'(1));
    assign one_left   = (rem_q != '0) && (rem_next == '0);

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        low_pos = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                low_pos = IDX_W'(i);
            end
        end
    end

    // in_ready is forced low during reset so no chunk looks accepted while the
    // state register is still being cleared.
    assign in_ready_o = (state_q == IDLE) && !rst_i;
    assign accept     = in_ready_o && in_valid_i;
    assign handshake  = (state_q == SCAN) && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (and_mask_i != '0)) state_d = SCAN;
            SCAN: if (out_ready_i && one_left) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            ifm_q   <= '0;
            filt_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            empty_q <= 1'b0;
            if (accept) begin
                rem_q   <= and_mask_i;
                ifm_q   <= IFM_mask_i;
                filt_q  <= filter_mask_i;
                empty_q <= (and_mask_i == '0);
            end else if (handshake) begin
                rem_q <= rem_next;
            end
        end
    end

    // Descriptor fields are zero outside SCAN so idle outputs are clean.
    always_comb begin
        out_valid_o = 1'b0;
        pos_o       = '0;
        ifm_idx_o   = '0;
        filt_idx_o  = '0;
        last_o      = 1'b0;
        if (state_q == SCAN) begin
            out_valid_o = 1'b1;
            pos_o       = low_pos;
            ifm_idx_o   = popcount(ifm_q & below_mask);
            filt_idx_o  = popcount(filt_q & below_mask);
            last_o      = one_left;
        end
    end

    assign empty_o = empty_q;

`ifdef MATCH_PICKER_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign match_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_nonzero_match_picker.sv
// tb/tb_nonzero_match_picker.sv - directed scoreboard bench for nonzero_match_picker
module tb_nonzero_match_picker;

    localparam int SIZE  = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  and_mask;
    logic [SIZE-1:0]  ifm_mask;
    logic [SIZE-1:0]  filt_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] ifm_idx;
    logic [IDX_W-1:0] filt_idx;
    logic             last;
    logic             empty;
`ifdef MATCH_PICKER_CNT_EN
    logic [15:0]      match_cnt;
`endif

    always #5 clk = ~clk;

    nonzero_match_picker #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .and_mask_i    (and_mask),
        .IFM_mask_i    (ifm_mask),
        .filter_mask_i (filt_mask),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .pos_o         (pos),
        .ifm_idx_o     (ifm_idx),
        .filt_idx_o    (filt_idx),
        .last_o        (last),
        .empty_o       (empty)
`ifdef MATCH_PICKER_CNT_EN
        ,
        .match_cnt_o   (match_cnt)
`endif
    );

    typedef struct {
        logic [IDX_W-1:0] pos;
        logic [IDX_W-1:0] ifm;
        logic [IDX_W-1:0] filt;
        logic             last;
    } desc_t;

    desc_t sb[$];
    int    total   = 0;
    int    passed  = 0;
    int    failed  = 0;
    int    exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t mk(input int p, input int i, input int f, input logic l);
        desc_t d;
        d.pos  = IDX_W'(p);
        d.ifm  = IDX_W'(i);
        d.filt = IDX_W'(f);
        d.last = l;
        return d;
    endfunction

    // Reference: every set position, offsets counted bit by bit below it.
    function automatic void model(input logic [SIZE-1:0] am, input logic [SIZE-1:0] im,
                                  input logic [SIZE-1:0] fm);
        int ci, cf;
        logic higher;
        for (int p = 0; p < SIZE; p++) begin
            if (am[p]) begin
                ci = 0;
                cf = 0;
                for (int j = 0; j < p; j++) begin
                    ci += int'(im[j]);
                    cf += int'(fm[j]);
                end
                higher = 1'b0;
                for (int j = p + 1; j < SIZE; j++) begin
                    if (am[j]) higher = 1'b1;
                end
                sb.push_back(mk(p, ci, cf, !higher));
            end
        end
    endfunction

    task automatic send(input logic [SIZE-1:0] am, input logic [SIZE-1:0] im,
                        input logic [SIZE-1:0] fm);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_at_send", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        and_mask  = am;
        ifm_mask  = im;
        filt_mask = fm;
        @(negedge clk);
        in_valid  = 1'b0;
        and_mask  = SIZE'($urandom);
        ifm_mask  = SIZE'($urandom);
        filt_mask = SIZE'($urandom);
    endtask

    task automatic drain(input int n);
        desc_t d;
        out_ready = 1'b1;
        for (int k = 0; k < n && sb.size() > 0; k++) begin
            int w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            d = sb.pop_front();
            check("out_valid", 32'(out_valid), 32'd1);
            check("pos", 32'(pos), 32'(d.pos));
            check("ifm_idx", 32'(ifm_idx), 32'(d.ifm));
            check("filt_idx", 32'(filt_idx), 32'(d.filt));
            check("last", 32'(last), 32'(d.last));
            check("empty_with_valid", 32'(empty), 32'd0);
            exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        and_mask  = '0;
        ifm_mask  = '0;
        filt_mask = '0;

        // Reset held for three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_last", 32'(last), 32'd0);
            check("rst_empty", 32'(empty), 32'd0);
            check("rst_pos", 32'(pos), 32'd0);
            check("rst_ifm_idx", 32'(ifm_idx), 32'd0);
            check("rst_filt_idx", 32'(filt_idx), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        check("post_rst_empty", 32'(empty), 32'd0);
`ifdef MATCH_PICKER_CNT_EN
        check("post_rst_cnt", 32'(match_cnt), 32'd0);
`endif

        // Mixed matches, full throughput
        out_ready = 1'b1;
        sb.push_back(mk(1, 0, 1, 1'b0));
        sb.push_back(mk(4, 2, 2, 1'b0));
        sb.push_back(mk(7, 4, 4, 1'b1));
        send(8'b1001_0010, 8'b1011_0110, 8'b1101_0011);
        check("mixed_latency_valid", 32'(out_valid), 32'd1);
        drain(3);
        check_idle("mixed_done");

        // Full mask: pos counts 0..7 with both offsets equal to pos
        model(8'hFF, 8'hFF, 8'hFF);
        send(8'hFF, 8'hFF, 8'hFF);
        drain(8);
        check_idle("full_done");
`ifdef MATCH_PICKER_CNT_EN
        check("cnt_mixed_full", 32'(match_cnt), 32'd11);
`endif

        // Backpressure on the second descriptor, with input noise during SCAN
        model(8'b1001_0010, 8'b1011_0110, 8'b1101_0011);
        send(8'b1001_0010, 8'b1011_0110, 8'b1101_0011);
        drain(1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pos", 32'(pos), 32'd4);
            check("bp_ifm_idx", 32'(ifm_idx), 32'd2);
            check("bp_filt_idx", 32'(filt_idx), 32'd2);
            check("bp_last", 32'(last), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            and_mask  = SIZE'($urandom);
            ifm_mask  = SIZE'($urandom);
            filt_mask = SIZE'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain(2);
        check_idle("bp_done");

        // Empty chunk followed immediately by another chunk
        send(8'h00, 8'b0101_0101, 8'b1010_1010);
        check("empty_pulse", 32'(empty), 32'd1);
        check("empty_out_valid", 32'(out_valid), 32'd0);
        check("empty_in_ready", 32'(in_ready), 32'd1);
        model(8'b0000_0101, 8'b0110_0101, 8'b1000_1111);
        send(8'b0000_0101, 8'b0110_0101, 8'b1000_1111);
        check("empty_pulse_end", 32'(empty), 32'd0);
        drain(2);
        check_idle("after_empty");
`ifdef MATCH_PICKER_CNT_EN
        check("cnt_before_abort", 32'(match_cnt), 32'(exp_cnt));
`endif

        // Full chunk abandoned by reset after three descriptors
        model(8'hFF, 8'hFF, 8'hFF);
        send(8'hFF, 8'hFF, 8'hFF);
        drain(3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_last", 32'(last), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        exp_cnt = 0;
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_release");
`ifdef MATCH_PICKER_CNT_EN
        check("cnt_after_abort", 32'(match_cnt), 32'd0);
`endif

        // Single match at the top bit
        sb.push_back(mk(7, 7, 3, 1'b1));
        send(8'b1000_0000, 8'hFF, 8'b1010_1010);
        drain(1);
        check_idle("top_bit_done");
`ifdef MATCH_PICKER_CNT_EN
        check("cnt_final", 32'(match_cnt), 32'(exp_cnt));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nonzero_match_picker.md
# nonzero_match_picker

Sequential consumer of the AND-gate stage in the sparse MAC datapath. Takes one chunk of the IFM/filter AND match mask plus both original sparsity bitmaps. It emits the surviving (both-nonzero) positions one per cycle, lowest index first. Each position comes with the compressed-array offsets for the IFM and filter data, computed as prefix popcounts. Its output feeds the compressed-data fetch and MAC stage.

## Interface
- `SIZE`, default `` `PREFIX_SUM_SIZE ``: bitmap chunk width in bits.
- `IDX_W`, default `$clog2(SIZE)`: width of position and offset outputs.

- `clk_i`, input, 1: clock, all logic on rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `in_valid_i`, input, 1: chunk present on the input buses.
- `in_ready_o`, output, 1: block can accept a chunk.
- `and_mask_i`, input, SIZE: AND-gate output, IFM_i & filter_i.
- `IFM_mask_i`, input, SIZE: IFM sparsity bitmap for the same chunk.
- `filter_mask_i`, input, SIZE: filter sparsity bitmap for the same chunk.
- `out_valid_o`, output, 1: match descriptor valid.
- `out_ready_i`, input, 1: downstream accepts the descriptor.
- `pos_o`, output, IDX_W: bit position of the current match.
- `ifm_idx_o`, output, IDX_W: popcount of `IFM_mask` bits strictly below `pos_o`.
- `filt_idx_o`, output, IDX_W: popcount of `filter_mask` bits strictly below `pos_o`.
- `last_o`, output, 1: current descriptor is the final match of the chunk.
- `empty_o`, output, 1: one-cycle pulse; an accepted chunk had no matches.
- `match_cnt_o`, output, 16: exists only with `MATCH_PICKER_CNT_EN`; see Configuration.

## Operation
State machine with two states, IDLE and SCAN.

**Registers**
- `rem_q`, SIZE bits: matches still to emit.
- `ifm_q`, SIZE bits: latched IFM bitmap.
- `filt_q`, SIZE bits: latched filter bitmap.

**IDLE**
- `in_ready_o` = 1.
- On `in_valid_i`:
  - Latch all three masks; `rem_q` takes `and_mask_i`.
  - If `and_mask_i` is nonzero, go to SCAN.
  - If `and_mask_i` == 0, stay in IDLE and pulse `empty_o` in the next cycle.

**SCAN**
- `in_ready_o` = 0.
- `out_valid_o` = 1.
- `pos_o` = index of the lowest set bit of `rem_q`, from a priority encoder.
- `ifm_idx_o` = popcount(`ifm_q` & ((1<<`pos_o`)-1)).
- `filt_idx_o` = popcount(`filt_q` & ((1<<`pos_o`)-1)).
- `last_o` = 1 when `rem_q` has exactly one bit set.
- On `out_ready_i`, clear the lowest set bit of `rem_q`. If `last_o` was 1, go to IDLE.
- With `out_ready_i` = 0, every output holds stable. `out_valid_o` never drops without a handshake.

**Rules**
- Offsets never exceed SIZE-1, so IDX_W bits suffice.
- All outputs are combinational from registered state only; there is no input-to-output combinational path.
- `empty_o` and `out_valid_o` are never high in the same cycle.

## Timing
**Reset values.** While `rst_i` = 1, and in the first cycle after it:
- State is IDLE and `rem_q`, `ifm_q`, `filt_q` = 0.
- `out_valid_o` = 0, `last_o` = 0, `empty_o` = 0, `pos_o` = 0, both offsets = 0.
- `in_ready_o` = 0 while `rst_i` is high and 1 from the first cycle after.

**Latency and throughput**
- A chunk accepted at edge N gives its first descriptor valid in cycle N+1.
- A chunk with k matches, with `out_ready_i` held high, occupies k SCAN cycles plus one IDLE cycle before the next chunk is accepted.
- A zero chunk costs one cycle.

**Boundary conditions**
- Reset mid-SCAN abandons the chunk. There is no `last_o`, and `out_valid_o` is 0 in the cycle after `rst_i` rises.
- A full mask (all ones) emits SIZE descriptors with `pos_o` counting 0..SIZE-1 and `ifm_idx_o` = `filt_idx_o` = `pos_o`.
- A match at bit SIZE-1 alone gives `last_o` on the first descriptor.
- Input changes while in SCAN are ignored.

## Configuration
- **`MATCH_PICKER_CNT_EN` defined:**
  - Adds `match_cnt_o`, a 16-bit counter of completed output handshakes since reset.
  - It saturates at 16'hFFFF and resets to 0.
  - It increments in the cycle after the handshake.
- **Not defined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_i` for 3 cycles, then release -> all outputs 0 during reset; `in_ready_o` = 1 in the first cycle after release.
- **Mixed matches,** SIZE = 8, `IFM_mask` = 8'b1011_0110, `filter_mask` = 8'b1101_0011, `and_mask` = 8'b1001_0010, `out_ready_i` = 1:
  - Descriptors (`pos_o`, `ifm_idx_o`, `filt_idx_o`) = (1,0,1), (4,2,2), (7,4,4).
  - `last_o` only on the third.
  - `in_ready_o` back to 1 one cycle later.
- **Backpressure:** same chunk, `out_ready_i` = 0 for 4 cycles on the second descriptor -> (4,2,2) held stable with `out_valid_o` = 1, then the sequence resumes unchanged.
- **Empty chunk:** `and_mask` = 0 -> `empty_o` is a one-cycle pulse, `out_valid_o` stays 0, and the next chunk is accepted the following cycle.
- **Full and reset mid-SCAN:** `and_mask` = all ones, assert `rst_i` after 3 descriptors -> `out_valid_o` = 0 next cycle, no `last_o`; a fresh 8'b1000_0000 chunk then yields the single descriptor (7, ·, ·) with `last_o` = 1.
- **With `MATCH_PICKER_CNT_EN`:** after the mixed and full-chunk scenarios without reset -> `match_cnt_o` = 3 + 8 = 11.
